// File: rtl/bcd_timekeeper_if.sv
// Control/status bundle between the timekeeper and its user (LCD controller / panel).
// The master drives mode, buttons and arm switch; the slave returns time, alarm and flags.
interface bcd_timekeeper_if;
    logic [1:0]  set_mode;
    logic        btn_hour;
    logic        btn_min;
    logic        alarm_en;
    logic [23:0] clockdata;
    logic [23:0] alarmdata;
    logic        is_am;
    logic        alarm_en_out;
    logic        alarm_ring;
    logic        sec_tick;

    modport master (
        output set_mode, btn_hour, btn_min, alarm_en,
        input  clockdata, alarmdata, is_am, alarm_en_out, alarm_ring, sec_tick
    );

    modport slave (
        input  set_mode, btn_hour, btn_min, alarm_en,
        output clockdata, alarmdata, is_am, alarm_en_out, alarm_ring, sec_tick
    );
endinterface

// File: rtl/bcd_timekeeper.sv
// 24-hour BCD time base with button-driven time/alarm setting and a timed alarm ring flag.
// Every output is driven straight from a flop.
module bcd_timekeeper #(
    parameter int TICK_DIV = 1000,
    parameter int RING_SEC = 30
) (
    input  logic            clk,
    input  logic            reset,
    bcd_timekeeper_if.slave bus
);
    localparam int            PW        = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_TOP = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0] PRESC_ONE = PW'(1);
    localparam logic [7:0]    RING_LOAD = 8'(RING_SEC);

    // Two-digit BCD increment that wraps to 00 after lim.
    function automatic logic [7:0] bcd2_inc(input logic [7:0] v, input logic [7:0] lim);
        logic [7:0] r;
        if (v == lim) begin
            r = 8'h00;
        end else if (v[3:0] == 4'h9) begin
            r = {v[7:4] + 4'h1, 4'h0};
        end else begin
            r = {v[7:4], v[3:0] + 4'h1};
        end
        return r;
    endfunction

    logic [PW-1:0] presc_r;
    logic [7:0]    hr_r, min_r, sec_r, al_hr_r, al_min_r, ring_cnt_r;
    logic          is_am_r, aen_r, ring_r, tick_r, silence_r;
    logic [2:0]    hsync_r, msync_r;

    logic          run_s, set_time_s, set_alarm_s, tick_s, match_s;
    logic          hour_edge_s, min_edge_s, sec_carry_s, min_carry_s;
    logic [PW-1:0] presc_n_s;
    logic [7:0]    hr_n_s, min_n_s, sec_n_s, al_hr_n_s, al_min_n_s;

    assign hour_edge_s = hsync_r[1] & ~hsync_r[2];
    assign min_edge_s  = msync_r[1] & ~msync_r[2];

    // Synchroniser stages [1:0] plus the history flop [2] for rising-edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hsync_r <= 3'b000;
            msync_r <= 3'b000;
        end else begin
            hsync_r <= {hsync_r[1:0], bus.btn_hour};
            msync_r <= {msync_r[1:0], bus.btn_min};
        end
    end

    // Mode decode; the unused encoding behaves as run.
    always_comb begin
        run_s       = 1'b0;
        set_time_s  = 1'b0;
        set_alarm_s = 1'b0;
        case (bus.set_mode)
            2'b01:   set_time_s  = 1'b1;
            2'b10:   set_alarm_s = 1'b1;
            default: run_s       = 1'b1;
        endcase
    end

    // Next time/alarm values: prescaler frozen while setting time, otherwise one second per tick.
    always_comb begin
        sec_carry_s = (sec_r == 8'h59);
        min_carry_s = (min_r == 8'h59);
        tick_s      = 1'b0;
        presc_n_s   = presc_r;
        hr_n_s      = hr_r;
        min_n_s     = min_r;
        sec_n_s     = sec_r;
        if (set_time_s) begin
            presc_n_s = {PW{1'b0}};
            sec_n_s   = 8'h00;
            if (hour_edge_s) begin
                hr_n_s = bcd2_inc(hr_r, 8'h23);
            end else begin
                hr_n_s = hr_r;
            end
            if (min_edge_s) begin
                min_n_s = bcd2_inc(min_r, 8'h59);
            end else begin
                min_n_s = min_r;
            end
        end else begin
            if (presc_r == PRESC_TOP) begin
                tick_s    = 1'b1;
                presc_n_s = {PW{1'b0}};
            end else begin
                presc_n_s = presc_r + PRESC_ONE;
            end
            if (tick_s) begin
                sec_n_s = bcd2_inc(sec_r, 8'h59);
                if (sec_carry_s) begin
                    min_n_s = bcd2_inc(min_r, 8'h59);
                end else begin
                    min_n_s = min_r;
                end
                if (sec_carry_s && min_carry_s) begin
                    hr_n_s = bcd2_inc(hr_r, 8'h23);
                end else begin
                    hr_n_s = hr_r;
                end
            end else begin
                sec_n_s = sec_r;
            end
        end
        if (set_alarm_s && hour_edge_s) begin
            al_hr_n_s = bcd2_inc(al_hr_r, 8'h23);
        end else begin
            al_hr_n_s = al_hr_r;
        end
        if (set_alarm_s && min_edge_s) begin
            al_min_n_s = bcd2_inc(al_min_r, 8'h59);
        end else begin
            al_min_n_s = al_min_r;
        end
    end

    // Only a tick can produce a match; set-mode edits onto equality never ring.
    assign match_s = tick_s & aen_r & ({hr_n_s, min_n_s, sec_n_s} == {al_hr_r, al_min_r, 8'h00});

    // Time, alarm, prescaler and the per-second flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc_r  <= {PW{1'b0}};
            hr_r     <= 8'h00;
            min_r    <= 8'h00;
            sec_r    <= 8'h00;
            al_hr_r  <= 8'h07;
            al_min_r <= 8'h00;
            tick_r   <= 1'b0;
            is_am_r  <= 1'b1;
        end else begin
            presc_r  <= presc_n_s;
            hr_r     <= hr_n_s;
            min_r    <= min_n_s;
            sec_r    <= sec_n_s;
            al_hr_r  <= al_hr_n_s;
            al_min_r <= al_min_n_s;
            tick_r   <= tick_s;
            is_am_r  <= (hr_n_s < 8'h12);
        end
    end

    // Arm latch and ring countdown; disarm beats match, match beats a silencing press.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            aen_r      <= 1'b0;
            silence_r  <= 1'b0;
            ring_r     <= 1'b0;
            ring_cnt_r <= 8'h00;
        end else begin
            aen_r     <= bus.alarm_en;
            silence_r <= run_s & (hour_edge_s | min_edge_s);
            if (!aen_r) begin
                ring_r     <= 1'b0;
                ring_cnt_r <= 8'h00;
            end else if (match_s) begin
                ring_r     <= 1'b1;
                ring_cnt_r <= RING_LOAD;
            end else if (silence_r && ring_r) begin
                ring_r     <= 1'b0;
                ring_cnt_r <= 8'h00;
            end else if (tick_s && ring_r) begin
                ring_cnt_r <= ring_cnt_r - 8'h01;
                ring_r     <= (ring_cnt_r != 8'h01);
            end else begin
                ring_r     <= ring_r;
                ring_cnt_r <= ring_cnt_r;
            end
        end
    end

    assign bus.clockdata    = {hr_r, min_r, sec_r};
    assign bus.alarmdata    = {al_hr_r, al_min_r, 8'h00};
    assign bus.is_am        = is_am_r;
    assign bus.alarm_en_out = aen_r;
    assign bus.alarm_ring   = ring_r;
    assign bus.sec_tick     = tick_r;
endmodule

// File: tb/tb_bcd_timekeeper.sv
// Bench for bcd_timekeeper: a table of directed steps, hand-written corner sequences and
// randomized stimulus, all compared cycle by cycle against an integer seconds-of-day model.
module tb_bcd_timekeeper;
    localparam int TD = 4;
    localparam int RS = 3;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   bad   = 0;

    bcd_timekeeper_if bus();
    bcd_timekeeper #(.TICK_DIV(TD), .RING_SEC(RS)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    // Reference model: time as seconds of day, alarm as minute of day, raw button history.
    int       m_t, m_al, m_presc, m_cnt;
    bit       m_tick, m_am, m_aen, m_ring, m_pend;
    bit [2:0] m_hh, m_mh;

    typedef struct {
        logic [1:0]  mode;
        bit          aen;
        int          hp;
        int          mp;
        int          ncyc;
        logic [23:0] clk_e;
        logic [23:0] al_e;
        bit          ring_e;
        bit          am_e;
    } vec_t;
    vec_t tbl [12];

    function automatic logic [7:0] bcd(input int v);
        logic [3:0] a, b;
        a = 4'(v / 10);
        b = 4'(v % 10);
        return {a, b};
    endfunction

    function automatic logic [23:0] exp_clock();
        return {bcd(m_t / 3600), bcd((m_t / 60) % 60), bcd(m_t % 60)};
    endfunction

    function automatic logic [23:0] exp_alarm();
        return {bcd(m_al / 60), bcd(m_al % 60), 8'h00};
    endfunction

    task automatic chk(input string nm, input logic [23:0] act, input logic [23:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        m_t = 0; m_al = 7 * 60; m_presc = 0; m_cnt = 0;
        m_tick = 1'b0; m_am = 1'b1; m_aen = 1'b0; m_ring = 1'b0; m_pend = 1'b0;
        m_hh = 3'b000; m_mh = 3'b000;
    endtask

    task automatic model_step(input logic [1:0] md, input bit bh, input bit bm, input bit ae);
        bit eh, em, st, sa, tk, match;
        int h, m, newt;
        // a raw level seen high two edges ago but low three edges ago is a press now
        eh = m_hh[1] & ~m_hh[2];
        em = m_mh[1] & ~m_mh[2];
        m_hh = {m_hh[1:0], bh};
        m_mh = {m_mh[1:0], bm};
        st = (md == 2'd1);
        sa = (md == 2'd2);
        tk = !st && (m_presc == TD - 1);
        m_presc = (st || tk) ? 0 : m_presc + 1;
        newt = m_t;
        if (st) begin
            h = m_t / 3600;
            m = (m_t / 60) % 60;
            if (eh) h = (h + 1) % 24;
            if (em) m = (m + 1) % 60;
            newt = h * 3600 + m * 60;
        end else if (tk) begin
            newt = (m_t + 1) % 86400;
        end
        match = tk && m_aen && (newt == m_al * 60);
        if (sa) begin
            h = m_al / 60;
            m = m_al % 60;
            if (eh) h = (h + 1) % 24;
            if (em) m = (m + 1) % 60;
            m_al = h * 60 + m;
        end
        if (!m_aen) begin
            m_ring = 1'b0; m_cnt = 0;
        end else if (match) begin
            m_ring = 1'b1; m_cnt = RS;
        end else if (m_pend && m_ring) begin
            m_ring = 1'b0; m_cnt = 0;
        end else if (tk && m_ring) begin
            m_cnt = m_cnt - 1;
            if (m_cnt == 0) m_ring = 1'b0;
        end
        m_pend = !st && !sa && (eh || em);
        m_aen  = ae;
        m_t    = newt;
        m_tick = tk;
        m_am   = (newt / 3600) < 12;
    endtask

    task automatic cyc();
        logic [1:0] md;
        bit bh, bm, ae;
        md = bus.set_mode; bh = bus.btn_hour; bm = bus.btn_min; ae = bus.alarm_en;
        @(posedge clk);
        model_step(md, bh, bm, ae);
        @(negedge clk);
        chk("clockdata", bus.clockdata, exp_clock());
        chk("alarmdata", bus.alarmdata, exp_alarm());
        chk("is_am", 24'(bus.is_am), 24'(m_am));
        chk("alarm_en_out", 24'(bus.alarm_en_out), 24'(m_aen));
        chk("alarm_ring", 24'(bus.alarm_ring), 24'(m_ring));
        chk("sec_tick", 24'(bus.sec_tick), 24'(m_tick));
    endtask

    task automatic press(input bit hour);
        if (hour) bus.btn_hour = 1'b1; else bus.btn_min = 1'b1;
        cyc(); cyc();
        bus.btn_hour = 1'b0; bus.btn_min = 1'b0;
        cyc(); cyc();
    endtask

    // Set the time to one minute before the alarm, then run to HH:MM:58 of that minute.
    task automatic setup_pre_alarm();
        int tgt, th, tm, hp, mp;
        bus.btn_hour = 1'b0; bus.btn_min = 1'b0; bus.set_mode = 2'b01;
        repeat (4) cyc();
        tgt = (m_al + 1439) % 1440;
        th = tgt / 60; tm = tgt % 60;
        hp = (th - m_t / 3600 + 24) % 24;
        mp = (tm - (m_t / 60) % 60 + 60) % 60;
        repeat (hp) press(1'b1);
        repeat (mp) press(1'b0);
        bus.set_mode = 2'b00;
        repeat (58 * TD) cyc();
        chk("setup_clock", bus.clockdata, {bcd(th), bcd(tm), 8'h58});
    endtask

    task automatic rand_seg(input int n);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 39) == 0) bus.set_mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 5) == 0) bus.btn_hour = ~bus.btn_hour;
            if ($urandom_range(0, 5) == 0) bus.btn_min = ~bus.btn_min;
            if ($urandom_range(0, 149) == 0) bus.alarm_en = ~bus.alarm_en;
            cyc();
        end
    endtask

    initial begin
        bus.set_mode = 2'b00; bus.btn_hour = 1'b0; bus.btn_min = 1'b0; bus.alarm_en = 1'b0;
        tbl[0]  = '{2'b00, 1'b0, 0,  0,  40,  24'h000010, 24'h070000, 1'b0, 1'b1};
        tbl[1]  = '{2'b00, 1'b0, 0,  0,  200, 24'h000100, 24'h070000, 1'b0, 1'b1};
        tbl[2]  = '{2'b01, 1'b0, 23, 58, 2,   24'h235900, 24'h070000, 1'b0, 1'b0};
        tbl[3]  = '{2'b00, 1'b0, 0,  0,  236, 24'h235959, 24'h070000, 1'b0, 1'b0};
        tbl[4]  = '{2'b00, 1'b0, 0,  0,  4,   24'h000000, 24'h070000, 1'b0, 1'b1};
        tbl[5]  = '{2'b01, 1'b0, 13, 61, 1,   24'h130100, 24'h070000, 1'b0, 1'b0};
        tbl[6]  = '{2'b10, 1'b0, 17, 2,  4,   24'h130120, 24'h000200, 1'b0, 1'b0};
        tbl[7]  = '{2'b01, 1'b0, 11, 0,  1,   24'h000100, 24'h000200, 1'b0, 1'b1};
        tbl[8]  = '{2'b00, 1'b1, 0,  0,  232, 24'h000158, 24'h000200, 1'b0, 1'b1};
        tbl[9]  = '{2'b00, 1'b1, 0,  0,  8,   24'h000200, 24'h000200, 1'b1, 1'b1};
        tbl[10] = '{2'b00, 1'b1, 0,  0,  8,   24'h000202, 24'h000200, 1'b1, 1'b1};
        tbl[11] = '{2'b00, 1'b1, 0,  0,  4,   24'h000203, 24'h000200, 1'b0, 1'b1};

        repeat (2) @(negedge clk);
        chk("rst_clock", bus.clockdata, 24'h000000);
        chk("rst_alarm", bus.alarmdata, 24'h070000);
        chk("rst_is_am", 24'(bus.is_am), 24'h000001);
        chk("rst_ring", 24'(bus.alarm_ring), 24'h000000);
        chk("rst_tick", 24'(bus.sec_tick), 24'h000000);
        chk("rst_aen_out", 24'(bus.alarm_en_out), 24'h000000);
        reset = 1'b1;
        model_reset();

        for (int i = 0; i < 12; i++) begin
            bus.set_mode = tbl[i].mode;
            bus.alarm_en = tbl[i].aen;
            repeat (tbl[i].hp) press(1'b1);
            repeat (tbl[i].mp) press(1'b0);
            repeat (tbl[i].ncyc) cyc();
            chk($sformatf("row%0d_clock", i), bus.clockdata, tbl[i].clk_e);
            chk($sformatf("row%0d_alarm", i), bus.alarmdata, tbl[i].al_e);
            chk($sformatf("row%0d_ring", i), 24'(bus.alarm_ring), 24'(tbl[i].ring_e));
            chk($sformatf("row%0d_is_am", i), 24'(bus.is_am), 24'(tbl[i].am_e));
        end

        // button latency, held press, and editing time onto the alarm value
        bus.set_mode = 2'b01;
        cyc();
        chk("set_sec_zero", bus.clockdata, 24'h000200);
        bus.btn_hour = 1'b1;
        cyc(); cyc();
        chk("btn_edge2", bus.clockdata, 24'h000200);
        cyc();
        chk("btn_edge3", bus.clockdata, 24'h010200);
        repeat (17) cyc();
        chk("btn_hold_once", bus.clockdata, 24'h010200);
        bus.btn_hour = 1'b0;
        repeat (3) cyc();
        repeat (23) press(1'b1);
        repeat (4) cyc();
        chk("edit_eq_clock", bus.clockdata, 24'h000200);
        chk("edit_eq_noring", 24'(bus.alarm_ring), 24'h000000);
        repeat (59) press(1'b0);

        // silencing press while ringing
        bus.set_mode = 2'b00;
        repeat (58 * TD) cyc();
        chk("sil_pre_clock", bus.clockdata, 24'h000158);
        repeat (2 * TD) cyc();
        chk("sil_ring_on", 24'(bus.alarm_ring), 24'h000001);
        bus.btn_min = 1'b1;
        cyc(); cyc(); cyc();
        chk("sil_edge3", 24'(bus.alarm_ring), 24'h000001);
        cyc();
        chk("sil_edge4", 24'(bus.alarm_ring), 24'h000000);
        bus.btn_min = 1'b0;
        repeat (4) cyc();

        // disarmed: reaching the alarm time does not ring
        bus.alarm_en = 1'b0;
        setup_pre_alarm();
        repeat (2 * TD) cyc();
        chk("noen_clock", bus.clockdata, 24'h000200);
        chk("noen_ring", 24'(bus.alarm_ring), 24'h000000);

        // disarming mid-ring
        bus.alarm_en = 1'b1;
        setup_pre_alarm();
        repeat (2 * TD) cyc();
        chk("drop_ring_on", 24'(bus.alarm_ring), 24'h000001);
        bus.alarm_en = 1'b0;
        cyc();
        chk("drop_edge1", 24'(bus.alarm_ring), 24'h000001);
        cyc();
        chk("drop_edge2", 24'(bus.alarm_ring), 24'h000000);

        for (int s = 0; s < 4; s++) begin
            bus.alarm_en = 1'b1;
            setup_pre_alarm();
            rand_seg(300);
        end

        // asynchronous reset between edges while in set-alarm mode
        bus.btn_hour = 1'b0; bus.btn_min = 1'b0; bus.set_mode = 2'b10; bus.alarm_en = 1'b1;
        repeat (6) cyc();
        press(1'b0);
        cyc();
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("arst_clock", bus.clockdata, 24'h000000);
        chk("arst_alarm", bus.alarmdata, 24'h070000);
        chk("arst_is_am", 24'(bus.is_am), 24'h000001);
        chk("arst_ring", 24'(bus.alarm_ring), 24'h000000);
        chk("arst_tick", 24'(bus.sec_tick), 24'h000000);
        chk("arst_aen_out", 24'(bus.alarm_en_out), 24'h000000);
        @(negedge clk);
        @(negedge clk);
        bus.set_mode = 2'b00;
        reset = 1'b1;
        model_reset();
        repeat (12) cyc();
        chk("post_rst_clock", bus.clockdata, 24'h000003);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
